alu_sequencer: RTL and testbench

- Control block that sequences the 64-bit ALU result mux and its single- and multi-cycle functional units.
- Accepts one operation at a time from the control path through a valid/ready handshake and drives the 4-bit mux select.
- Pulses a start strobe for multi-cycle units (MUL, DIV) and waits the configured latency.
- Captures the selected 64-bit result into an output register and presents it with valid/ready.

---
 rtl/alu_sequencer.sv | 114 +++++++++++
 tb/tb_alu_sequencer.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: sequences the ALU result mux and multi-cycle MUL/DIV units, registering the selected result
//   clk        : rising-edge clock
//   clr        : asynchronous active-low reset
//   req_*      : operation request handshake (op code, divisor-is-zero flag)
//   mux_select : ALU result mux select, valid while busy
//   unit_start : one-cycle start strobe for MUL/DIV
//   alu_result : ALU result mux output
//   res_*      : registered result handshake, res_err flags DIV by zero
//   busy       : high outside IDLE
module alu_sequencer #(
    parameter int WIDTH      = 64,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_op,
    input  logic             b_zero,
    output logic [3:0]       mux_select,
    output logic             unit_start,
    input  logic [WIDTH-1:0] alu_result,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_err,
    output logic             busy
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [3:0]       op_q;
    logic             bz_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             err_q, err_d;
    logic             multi, div0;

    // 0xE/0xF are the multi-cycle units; DIV with a zero divisor never starts the unit
    assign multi = op_q[3:1] == 3'b111;
    assign div0  = op_q == 4'hF && bz_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        err_d   = err_q;
        case (state_q)
            IDLE: state_d = req_valid ? EXEC : IDLE;
            EXEC: begin
                if (div0) begin
                    data_d  = '1;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else if (multi) begin
                    cnt_d   = op_q[0] ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MUL_CYCLES - 1);
                    state_d = WAIT;
                end else begin
                    data_d  = alu_result;
                    err_d   = 1'b0;
                    state_d = DONE;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    data_d  = alu_result;
                    err_d   = 1'b0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                if (res_ready) begin
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= IDLE;
            op_q    <= '0;
            bz_q    <= 1'b0;
            cnt_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            err_q   <= err_d;
            if (state_q == IDLE && req_valid) begin
                op_q <= req_op;
                bz_q <= b_zero;
            end
        end
    end

    assign req_ready  = state_q == IDLE;
    assign busy       = state_q != IDLE;
    assign mux_select = busy ? op_q : 4'h0;
    assign unit_start = state_q == EXEC && multi && !div0;
    assign res_valid  = state_q == DONE;
    assign res_data   = data_q;
    assign res_err    = err_q;
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: randomized self-checking bench for alu_sequencer against a latency/result reference model
module tb_alu_sequencer;
    localparam int W  = 64;
    localparam int MC = 4;
    localparam int DC = 32;

    logic         clk = 1'b0;
    logic         clr = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [3:0]   req_op = 4'h0;
    logic         b_zero = 1'b0;
    logic [3:0]   mux_select;
    logic         unit_start;
    logic [W-1:0] alu_result = '0;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [W-1:0] res_data;
    logic         res_err;
    logic         busy;

    int passed = 0;
    int total  = 0;

    alu_sequencer #(.WIDTH(W), .MUL_CYCLES(MC), .DIV_CYCLES(DC), .CNT_W(6)) dut (
        .clk(clk), .clr(clr), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .b_zero(b_zero), .mux_select(mux_select), .unit_start(unit_start), .alu_result(alu_result),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // Cycles from the accept edge until res_valid is seen
    function automatic int lat_of(input logic [3:0] op, input logic bz);
        return (op == 4'hE) ? MC + 2 : (op == 4'hF && !bz) ? DC + 2 : 2;
    endfunction

    task automatic run_op(input logic [3:0] op, input logic bz, input logic [3:0] aop,
                          input int hold, input bit fixed, input logic [W-1:0] fv);
        int lat;
        logic st, exp_e;
        logic [W-1:0] exp_d;
        lat   = lat_of(op, bz);
        st    = op >= 4'hE && !(op == 4'hF && bz);
        exp_e = op == 4'hF && bz;
        exp_d = '0;
        req_valid = 1'b1; req_op = op; b_zero = bz; res_ready = 1'b0;
        total++; if (req_ready !== 1'b1) $display("FAIL accept_ready op=%h got %b want 1", op, req_ready); else passed++;
        @(posedge clk); #1;
        req_op = aop; b_zero = 1'($urandom); req_valid = 1'($urandom);
        for (int c = 1; c <= lat; c++) begin
            total++; if (busy !== 1'b1) $display("FAIL busy op=%h c=%0d got %b want 1", op, c, busy); else passed++;
            total++; if (mux_select !== op) $display("FAIL mux op=%h c=%0d got %h want %h", op, c, mux_select, op); else passed++;
            total++; if (unit_start !== (st && c == 1)) $display("FAIL start op=%h c=%0d got %b want %b", op, c, unit_start, st && c == 1); else passed++;
            total++; if (res_valid !== (c == lat)) $display("FAIL valid_timing op=%h c=%0d got %b want %b", op, c, res_valid, c == lat); else passed++;
            total++; if (req_ready !== 1'b0) $display("FAIL busy_ready op=%h c=%0d got %b want 0", op, c, req_ready); else passed++;
            alu_result = (fixed && c == lat - 1) ? fv : {$urandom, $urandom};
            if (c == lat - 1) exp_d = exp_e ? '1 : alu_result;
            if (c < lat) begin @(posedge clk); #1; end
        end
        total++; if (res_data !== exp_d) $display("FAIL data op=%h got %h want %h", op, res_data, exp_d); else passed++;
        total++; if (res_err !== exp_e) $display("FAIL err op=%h got %b want %b", op, res_err, exp_e); else passed++;
        repeat (hold) begin
            @(posedge clk); #1;
            req_valid = 1'b1; req_op = 4'($urandom); alu_result = {$urandom, $urandom};
            total++; if (res_valid !== 1'b1) $display("FAIL hold_valid op=%h got %b want 1", op, res_valid); else passed++;
            total++; if (res_data !== exp_d) $display("FAIL hold_data op=%h got %h want %h", op, res_data, exp_d); else passed++;
            total++; if (res_err !== exp_e) $display("FAIL hold_err op=%h got %b want %b", op, res_err, exp_e); else passed++;
            total++; if (req_ready !== 1'b0) $display("FAIL hold_ready op=%h got %b want 0", op, req_ready); else passed++;
        end
        res_ready = 1'b1; req_valid = 1'b0;
        @(posedge clk); #1;
        res_ready = 1'b0;
        total++; if (busy !== 1'b0) $display("FAIL idle_busy op=%h got %b want 0", op, busy); else passed++;
        total++; if (req_ready !== 1'b1) $display("FAIL idle_ready op=%h got %b want 1", op, req_ready); else passed++;
        total++; if (res_valid !== 1'b0) $display("FAIL idle_valid op=%h got %b want 0", op, res_valid); else passed++;
        total++; if (res_err !== 1'b0) $display("FAIL idle_err op=%h got %b want 0", op, res_err); else passed++;
        total++; if (res_data !== exp_d) $display("FAIL idle_data op=%h got %h want %h", op, res_data, exp_d); else passed++;
    endtask

    task automatic check_reset_outputs(input string tag);
        total++; if (req_ready !== 1'b1) $display("FAIL %s_ready got %b want 1", tag, req_ready); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL %s_busy got %b want 0", tag, busy); else passed++;
        total++; if (mux_select !== 4'h0) $display("FAIL %s_mux got %h want 0", tag, mux_select); else passed++;
        total++; if (unit_start !== 1'b0) $display("FAIL %s_start got %b want 0", tag, unit_start); else passed++;
        total++; if (res_valid !== 1'b0) $display("FAIL %s_valid got %b want 0", tag, res_valid); else passed++;
        total++; if (res_data !== '0) $display("FAIL %s_data got %h want 0", tag, res_data); else passed++;
        total++; if (res_err !== 1'b0) $display("FAIL %s_err got %b want 0", tag, res_err); else passed++;
    endtask

    task automatic test_reset();
        clr = 1'b0; req_valid = 1'b1; req_op = 4'hE;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        req_valid = 1'b0; clr = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        run_op(4'h3, 1'b0, 4'h3, 0, 1'b1, 64'h0000_0000_0000_00AB);
    endtask

    task automatic test_mul();
        run_op(4'hE, 1'b0, 4'hE, 0, 1'b1, 64'h1234);
    endtask

    task automatic test_div();
        run_op(4'hF, 1'b1, 4'hF, 0, 1'b0, '0);
        run_op(4'hF, 1'b0, 4'h1, 2, 1'b0, '0);
    endtask

    task automatic test_backpressure();
        run_op(4'h7, 1'b0, 4'h7, 10, 1'b0, '0);
    endtask

    task automatic test_op_change();
        run_op(4'h2, 1'b0, 4'hE, 0, 1'b0, '0);
    endtask

    task automatic test_reset_mid();
        req_valid = 1'b1; req_op = 4'hF; b_zero = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        clr = 1'b0; #1;
        check_reset_outputs("midreset");
        @(posedge clk); #1;
        clr = 1'b1;
        repeat (DC + 4) begin
            @(posedge clk); #1;
            total++; if (res_valid !== 1'b0 || busy !== 1'b0) $display("FAIL post_reset valid=%b busy=%b want 0 0", res_valid, busy); else passed++;
        end
        run_op(4'hE, 1'b0, 4'hE, 1, 1'b0, '0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 24; i++) begin
            logic [3:0] op;
            op = (i % 4 == 0) ? 4'hE : (i % 6 == 0) ? 4'hF : 4'($urandom);
            run_op(op, 1'($urandom), 4'($urandom), int'($urandom_range(0, 3)), 1'b0, '0);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_mul();
        test_div();
        test_backpressure();
        test_op_change();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
